// File: rtl/aes_out_buffer.sv
// Show-ahead output FIFO behind the AES GCM stage, with overflow recovery.
// After an overflow the rest of the packet is dropped and its tail is stored flagged as an error.
module aes_out_buffer #(
    parameter int DEPTH        = 16,
    parameter int AFULL_THRESH = 12
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_ready,
    input  logic [127:0]               i_cipher,
    input  logic [288:0]               i_text,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic [415:0]               m_tdata,
    output logic                       m_tlast,
    output logic                       m_tuser,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_almost_full,
    output logic                       o_overflow,
    output logic [31:0]                o_pkt_cnt,
    output logic [31:0]                o_drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {PASS = 1'b0, DROP = 1'b1} state_t;

    state_t          state, state_next;
    logic [417:0]    mem [DEPTH];
    logic [417:0]    head;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count, count_next;
    logic [31:0]     pkt_cnt, drop_cnt;
    logic            afull, overflow;
    logic            pop, push, drop, wr_err, ovf_set, space;

    assign m_tvalid = (count != '0);
    assign pop      = m_tvalid && m_tready;
    assign space    = (count != CW'(DEPTH)) || pop;

    assign head     = mem[rd_ptr];
    assign m_tdata  = head[417:2];
    assign m_tlast  = head[1];
    assign m_tuser  = head[0];

    assign o_count       = count;
    assign o_almost_full = afull;
    assign o_overflow    = overflow;
    assign o_pkt_cnt     = pkt_cnt;
    assign o_drop_cnt    = drop_cnt;

    always_ff @(posedge clk) begin
        if (reset) state <= PASS;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            PASS: if (i_ready && !space) state_next = DROP;
            DROP: if (i_ready && i_text[0] && space) state_next = PASS;
            default: state_next = PASS;
        endcase
    end

    // In DROP only a packet tail may enter, and it carries the error flag.
    always_comb begin
        push    = 1'b0;
        drop    = 1'b0;
        wr_err  = 1'b0;
        ovf_set = 1'b0;
        if (i_ready) begin
            case (state)
                PASS: begin
                    if (space) push = 1'b1;
                    else begin
                        drop    = 1'b1;
                        ovf_set = 1'b1;
                    end
                end
                DROP: begin
                    if (i_text[0] && space) begin
                        push   = 1'b1;
                        wr_err = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end
                default: drop = 1'b1;
            endcase
        end
    end

    assign count_next = count + CW'(push) - CW'(pop);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {i_cipher, i_text[288:1], i_text[0], wr_err};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            afull    <= 1'b0;
            overflow <= 1'b0;
            pkt_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            // Registered from the next occupancy so it lines up with o_count.
            afull <= (count_next >= CW'(AFULL_THRESH));
            if (ovf_set) overflow <= 1'b1;
            if (pop && m_tlast && !m_tuser) pkt_cnt <= pkt_cnt + 32'd1;
            if (drop) drop_cnt <= drop_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_aes_out_buffer.sv
// Self-checking bench for aes_out_buffer: scoreboard on popped words plus table-driven status checks.
module tb_aes_out_buffer;
    logic          clk;
    logic          reset;
    logic          i_ready;
    logic [127:0]  i_cipher;
    logic [288:0]  i_text;
    logic          m_tvalid;
    logic          m_tready;
    logic [415:0]  m_tdata;
    logic          m_tlast;
    logic          m_tuser;
    logic [4:0]    o_count;
    logic          o_almost_full;
    logic          o_overflow;
    logic [31:0]   o_pkt_cnt;
    logic [31:0]   o_drop_cnt;

    aes_out_buffer #(.DEPTH(16), .AFULL_THRESH(12)) dut (
        .clk(clk), .reset(reset), .i_ready(i_ready), .i_cipher(i_cipher), .i_text(i_text),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
        .m_tuser(m_tuser), .o_count(o_count), .o_almost_full(o_almost_full),
        .o_overflow(o_overflow), .o_pkt_cnt(o_pkt_cnt), .o_drop_cnt(o_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [415:0] data;
        logic         last;
        logic         user;
    } exp_t;

    typedef struct {
        bit rdy; bit last; bit trdy; bit acc; bit err;
        int cnt; bit afull; bit ovf; int drop; int pkt;
    } vec_t;

    exp_t        sb[$];
    vec_t        tbl[$];
    int          errors = 0;
    int          checks = 0;
    int unsigned seq = 1;

    task automatic chk(input string name, input logic [415:0] act, input logic [415:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(bit rdy, bit last, bit trdy, bit acc, bit err,
                                int cnt, bit afull, bit ovf, int drop, int pkt);
        vec_t v;
        v.rdy = rdy; v.last = last; v.trdy = trdy; v.acc = acc; v.err = err;
        v.cnt = cnt; v.afull = afull; v.ovf = ovf; v.drop = drop; v.pkt = pkt;
        tbl.push_back(v);
    endfunction

    // Called just after a rising edge; returns just after the next rising edge.
    task automatic step(input bit rdy, input bit last, input bit trdy, input bit acc, input bit err);
        logic [31:0] s;
        exp_t        e;
        s = seq;
        seq++;
        i_ready  = rdy;
        i_cipher = {4{~s}};
        i_text   = {{9{s}}, last};
        m_tready = trdy;
        if (rdy && acc) begin
            e.data = {i_cipher, i_text[288:1]};
            e.last = last;
            e.user = err;
            sb.push_back(e);
        end
        @(negedge clk);
        if (m_tvalid && m_tready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got data %0h expected no output", m_tdata);
            end else begin
                e = sb.pop_front();
                chk("pop_data", m_tdata, e.data);
                chk("pop_tlast", 416'(m_tlast), 416'(e.last));
                chk("pop_tuser", 416'(m_tuser), 416'(e.user));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Full/almost-full, push+pop at full, overflow recovery, drain, then a clean packet.
        for (int i = 1; i <= 16; i++) add(1, 0, 0, 1, 0, i, i >= 12, 0, 0, 1);
        add(1, 0, 1, 1, 0, 16, 1, 0, 0, 1);
        add(1, 0, 1, 1, 0, 16, 1, 0, 0, 1);
        for (int i = 1; i <= 4; i++) add(1, 0, 0, 0, 0, 16, 1, 1, i, 1);
        for (int i = 15; i >= 12; i--) add(0, 0, 1, 0, 0, i, 1, 1, 4, 1);
        add(1, 0, 0, 0, 0, 12, 1, 1, 5, 1);
        add(1, 1, 0, 1, 1, 13, 1, 1, 5, 1);
        for (int i = 12; i >= 0; i--) add(0, 0, 1, 0, 0, i, i >= 12, 1, 5, 1);
        add(1, 1, 0, 1, 0, 1, 0, 1, 5, 1);
        add(0, 0, 1, 0, 0, 0, 0, 1, 5, 2);

        reset = 1'b1; i_ready = 1'b1; i_cipher = '0; i_text = '1; m_tready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_tvalid", 416'(m_tvalid), 416'(0));
        chk("rst_count", 416'(o_count), 416'(0));
        chk("rst_afull", 416'(o_almost_full), 416'(0));
        chk("rst_overflow", 416'(o_overflow), 416'(0));
        chk("rst_pkt_cnt", 416'(o_pkt_cnt), 416'(0));
        chk("rst_drop_cnt", 416'(o_drop_cnt), 416'(0));
        reset = 1'b0; i_ready = 1'b0;

        // Three-word packet streamed straight through.
        step(1, 0, 1, 1, 0);
        chk("p3_count1", 416'(o_count), 416'(1));
        step(1, 0, 1, 1, 0);
        step(1, 1, 1, 1, 0);
        chk("p3_count3", 416'(o_count), 416'(1));
        step(0, 0, 1, 0, 0);
        chk("p3_count_end", 416'(o_count), 416'(0));
        chk("p3_pkt_cnt", 416'(o_pkt_cnt), 416'(1));

        foreach (tbl[i]) begin
            step(tbl[i].rdy, tbl[i].last, tbl[i].trdy, tbl[i].acc, tbl[i].err);
            chk($sformatf("row%0d_count", i), 416'(o_count), 416'(tbl[i].cnt));
            chk($sformatf("row%0d_tvalid", i), 416'(m_tvalid), 416'(tbl[i].cnt != 0));
            chk($sformatf("row%0d_afull", i), 416'(o_almost_full), 416'(tbl[i].afull));
            chk($sformatf("row%0d_overflow", i), 416'(o_overflow), 416'(tbl[i].ovf));
            chk($sformatf("row%0d_drop_cnt", i), 416'(o_drop_cnt), 416'(tbl[i].drop));
            chk($sformatf("row%0d_pkt_cnt", i), 416'(o_pkt_cnt), 416'(tbl[i].pkt));
        end

        // Reset while in DROP with five entries stored.
        for (int i = 0; i < 16; i++) step(1, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 11; i++) step(0, 0, 1, 0, 0);
        chk("pre_rst_count", 416'(o_count), 416'(5));
        reset = 1'b1; i_ready = 1'b1; i_text = '1; m_tready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        chk("mid_rst_tvalid", 416'(m_tvalid), 416'(0));
        chk("mid_rst_count", 416'(o_count), 416'(0));
        chk("mid_rst_overflow", 416'(o_overflow), 416'(0));
        chk("mid_rst_drop_cnt", 416'(o_drop_cnt), 416'(0));
        chk("mid_rst_pkt_cnt", 416'(o_pkt_cnt), 416'(0));
        step(1, 1, 0, 1, 0);
        step(0, 0, 1, 0, 0);
        chk("post_rst_pkt_cnt", 416'(o_pkt_cnt), 416'(1));

        // Packet counter wrap from all-ones.
        step(1, 1, 0, 1, 0);
        force dut.pkt_cnt = 32'hFFFF_FFFF;
        #2;
        release dut.pkt_cnt;
        step(0, 0, 1, 0, 0);
        chk("pkt_cnt_wrap", 416'(o_pkt_cnt), 416'(0));

        chk("sb_drained", 416'(sb.size()), 416'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
